// File: rtl/hattrick_i2c_pkg.sv
// Shared encodings for the I2C register bridge: FSM states, pointer field widths, ACK levels.
package hattrick_i2c_pkg;

    localparam int PORT_W = 4;
    localparam int OFF_W  = 4;

    // SDA level seen on the ninth clock of a byte
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RD_FETCH,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    function automatic logic [15:0] offset_onehot(input logic [OFF_W-1:0] off);
        return 16'h0001 << off;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers, edge register and START/STOP detection.
// I2C_GLITCH_FILTER_EN adds a 3-sample stability filter after synchronization.
module i2c_line_sync (
    input  logic SYSCLK,
    input  logic RESET_N,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_lvl;
    logic       sda_lvl;
    logic       scl_prev;
    logic       sda_prev;

    // Reset to the idle-bus level so a reset never fabricates an edge
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_pin};
            sda_sync <= {sda_sync[0], sda_pin};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_filt;
    logic       sda_filt;

    // A new level is taken only when three consecutive samples agree
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            if (scl_sync[1] == scl_hist[0] && scl_hist[0] == scl_hist[1])
                scl_filt <= scl_sync[1];
            if (sda_sync[1] == sda_hist[0] && sda_hist[0] == sda_hist[1])
                sda_filt <= sda_sync[1];
        end
    end

    assign scl_lvl = scl_filt;
    assign sda_lvl = sda_filt;
`else
    assign scl_lvl = scl_sync[1];
    assign sda_lvl = sda_sync[1];
`endif

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_prev <= scl_lvl;
            sda_prev <= sda_lvl;
            scl_rise <= scl_lvl & ~scl_prev;
            scl_fall <= ~scl_lvl & scl_prev;
            start    <= scl_prev & scl_lvl & sda_prev & ~sda_lvl;
            stop     <= scl_prev & scl_lvl & ~sda_prev & sda_lvl;
        end
    end

    assign sda = sda_prev;

endmodule

// File: rtl/i2c_reg_bridge.sv
// I2C slave that turns address/pointer/data bytes into single-cycle register-port strobes.
// Build with I2C_GLITCH_FILTER_EN to enable the line glitch filter in i2c_line_sync.
module i2c_reg_bridge
    import hattrick_i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_PORTS  = 4
) (
    input  logic                   SYSCLK,
    input  logic                   RESET_N,
    input  logic                   SCL_IN,
    input  logic                   SDA_IN,
    output logic                   SDA_OE,
    output logic [NUM_PORTS-1:0]   PORT_CS,
    output logic [15:0]            OFFSET_SEL,
    output logic                   RD_WR,
    output logic [7:0]             DOUT,
    input  logic [8*NUM_PORTS-1:0] RDATA,
    output logic                   BUSY,
    output state_t                 fsm_state
);

    localparam logic [4:0] PORT_LIMIT = 5'(NUM_PORTS);

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_line_sync u_line_sync (
        .SYSCLK   (SYSCLK),
        .RESET_N  (RESET_N),
        .scl_pin  (SCL_IN),
        .sda_pin  (SDA_IN),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_t               state;
    logic [3:0]           bit_cnt;
    logic [7:0]           shreg;
    logic [PORT_W-1:0]    ptr_port;
    logic [OFF_W-1:0]     ptr_off;
    logic                 rw;
    logic [1:0]           fetch_cnt;
    logic [NUM_PORTS-1:0] port_dec;
    logic [7:0]           rd_byte;
    logic                 rx_state;
    logic                 rx_done;

    always_comb begin
        port_dec = '0;
        rd_byte  = 8'h00;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (ptr_port == PORT_W'(p)) begin
                port_dec[p] = 1'b1;
                rd_byte     = RDATA[8*p +: 8];
            end
        end
    end

    assign rx_state  = (state == ST_ADDR) || (state == ST_PTR) || (state == ST_WDATA);
    assign rx_done   = scl_fall && (bit_cnt == 4'd8);
    assign fsm_state = state;

    // Port access: PORT_CS is a one-cycle strobe with no back-pressure; OFFSET_SEL, RD_WR
    // and DOUT are valid with it and hold until the next strobe. A read port answers on the
    // clock edge that ends the strobe, and its byte is captured one cycle later.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            ptr_port   <= '0;
            ptr_off    <= '0;
            rw         <= 1'b0;
            fetch_cnt  <= 2'd0;
            SDA_OE     <= 1'b0;
            PORT_CS    <= '0;
            OFFSET_SEL <= 16'h0001;
            RD_WR      <= 1'b1;
            DOUT       <= 8'h00;
            BUSY       <= 1'b0;
        end else begin
            PORT_CS <= '0;
            if (stop) begin
                state  <= ST_IDLE;
                SDA_OE <= 1'b0;
                BUSY   <= 1'b0;
            end else if (start) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                SDA_OE  <= 1'b0;
            end else begin
                if (rx_state && scl_rise && bit_cnt != 4'd8) begin
                    shreg   <= {shreg[6:0], sda};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                case (state)
                    ST_ADDR: if (rx_done) begin
                        bit_cnt <= 4'd0;
                        if (shreg[7:1] == SLAVE_ADDR) begin
                            rw     <= shreg[0];
                            SDA_OE <= 1'b1;
                            BUSY   <= 1'b1;
                            state  <= ST_ADDR_ACK;
                        end else begin
                            BUSY  <= 1'b0;
                            state <= ST_IGNORE;
                        end
                    end
                    // A read keeps ACK low and fetches while SCL is high, so the first bit
                    // replaces ACK on the very next SCL fall.
                    ST_ADDR_ACK: begin
                        if (rw && scl_rise) begin
                            fetch_cnt <= 2'd0;
                            state     <= ST_RD_FETCH;
                        end else if (!rw && scl_fall) begin
                            SDA_OE <= 1'b0;
                            state  <= ST_PTR;
                        end
                    end
                    ST_PTR: if (rx_done) begin
                        bit_cnt <= 4'd0;
                        if ({1'b0, shreg[7:4]} < PORT_LIMIT) begin
                            ptr_port <= shreg[7:4];
                            ptr_off  <= shreg[3:0];
                            SDA_OE   <= 1'b1;
                            state    <= ST_PTR_ACK;
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                    ST_PTR_ACK: if (scl_fall) begin
                        SDA_OE <= 1'b0;
                        state  <= ST_WDATA;
                    end
                    ST_WDATA: begin
                        if (scl_rise && bit_cnt == 4'd7) begin
                            DOUT       <= {shreg[6:0], sda};
                            RD_WR      <= 1'b0;
                            OFFSET_SEL <= offset_onehot(ptr_off);
                            PORT_CS    <= port_dec;
                        end
                        if (rx_done) begin
                            bit_cnt <= 4'd0;
                            SDA_OE  <= 1'b1;
                            ptr_off <= ptr_off + OFF_W'(1);
                            state   <= ST_WDATA_ACK;
                        end
                    end
                    ST_WDATA_ACK: if (scl_fall) begin
                        SDA_OE <= 1'b0;
                        state  <= ST_WDATA;
                    end
                    ST_RD_FETCH: begin
                        fetch_cnt <= fetch_cnt + 2'd1;
                        if (fetch_cnt == 2'd0) begin
                            RD_WR      <= 1'b1;
                            OFFSET_SEL <= offset_onehot(ptr_off);
                            PORT_CS    <= port_dec;
                        end else if (fetch_cnt == 2'd2) begin
                            shreg   <= rd_byte;
                            bit_cnt <= 4'd0;
                            state   <= ST_RDATA;
                        end
                    end
                    ST_RDATA: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            SDA_OE  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= ST_RDATA_ACK;
                        end else begin
                            SDA_OE  <= ~shreg[7];
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ST_RDATA_ACK: if (scl_rise) begin
                        if (sda == ACK) begin
                            ptr_off   <= ptr_off + OFF_W'(1);
                            fetch_cnt <= 2'd0;
                            state     <= ST_RD_FETCH;
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Directed bench for i2c_reg_bridge: bus master tasks, register-port model and strobe scoreboard.
`timescale 1ns/1ps
module tb_i2c_reg_bridge;
    import hattrick_i2c_pkg::*;

    localparam int NUM_PORTS = 4;
    localparam int Q         = 10;
    localparam int W         = 19;

    logic                   SYSCLK  = 1'b0;
    logic                   RESET_N = 1'b0;
    logic                   scl_m   = 1'b1;
    logic                   sda_m   = 1'b1;
    logic                   sda_line;
    logic                   SDA_OE;
    logic [NUM_PORTS-1:0]   PORT_CS;
    logic [15:0]            OFFSET_SEL;
    logic                   RD_WR;
    logic [7:0]             DOUT;
    logic [8*NUM_PORTS-1:0] RDATA = '0;
    logic                   BUSY;
    state_t                 fsm_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic [NUM_PORTS-1:0] prev_cs = '0;

    assign sda_line = sda_m & ~SDA_OE;

    i2c_reg_bridge #(.SLAVE_ADDR(7'h50), .NUM_PORTS(NUM_PORTS)) dut (
        .SYSCLK     (SYSCLK),
        .RESET_N    (RESET_N),
        .SCL_IN     (scl_m),
        .SDA_IN     (sda_line),
        .SDA_OE     (SDA_OE),
        .PORT_CS    (PORT_CS),
        .OFFSET_SEL (OFFSET_SEL),
        .RD_WR      (RD_WR),
        .DOUT       (DOUT),
        .RDATA      (RDATA),
        .BUSY       (BUSY),
        .fsm_state  (fsm_state)
    );

    always #5 SYSCLK = ~SYSCLK;

    function automatic logic [4:0] oh16_idx(input logic [15:0] v);
        logic [4:0] r;
        int n;
        r = 5'h1F;
        n = 0;
        for (int i = 0; i < 16; i++) if (v[i]) begin r = 5'(i); n++; end
        return (n == 1) ? r : 5'h1F;
    endfunction

    function automatic logic [4:0] cs_idx(input logic [NUM_PORTS-1:0] v);
        logic [4:0] r;
        int n;
        r = 5'h1F;
        n = 0;
        for (int i = 0; i < NUM_PORTS; i++) if (v[i]) begin r = 5'(i); n++; end
        return (n == 1) ? r : 5'h1F;
    endfunction

    function automatic logic [W-1:0] pack(input logic rd, input logic [4:0] port,
                                          input logic [4:0] off, input logic [7:0] data);
        return {rd, port, off, data};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Register-port model: a read returns offset*3, registered on the strobe edge
    always @(posedge SYSCLK) begin
        for (int p = 0; p < NUM_PORTS; p++)
            if (PORT_CS[p] && RD_WR)
                RDATA[8*p +: 8] <= 8'(32'(oh16_idx(OFFSET_SEL)) * 3);
    end

    // Scoreboard: every strobe is popped against the access the stimulus announced
    always @(negedge SYSCLK) begin
        if (PORT_CS != '0) begin
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            check("strobe_width", 32'(prev_cs), 32'd0);
            if (exp_q.size() != 0)
                check("strobe_access",
                      32'(pack(RD_WR, cs_idx(PORT_CS), oh16_idx(OFFSET_SEL), RD_WR ? 8'h00 : DOUT)),
                      32'(exp_q.pop_front()));
        end
        prev_cs <= PORT_CS;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_q();
        repeat (Q) @(negedge SYSCLK);
    endtask

    task automatic clock_bit(input logic b, output logic seen);
        wait_q();
        sda_m = b;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        seen = sda_line;
        wait_q();
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_q();
        scl_m = 1'b1;
        wait_q();
        sda_m = 1'b1;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        acked = (s == 1'b0);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            b = {b[6:0], s};
        end
        clock_bit(master_ack ? 1'b0 : 1'b1, s);
    endtask

    initial begin
        logic       a;
        logic       s;
        logic [7:0] b;
        logic [7:0] gdata;

        repeat (5) @(negedge SYSCLK);
        check("rst_sda_oe", 32'(SDA_OE), 32'd0);
        check("rst_port_cs", 32'(PORT_CS), 32'd0);
        check("rst_offset_sel", 32'(OFFSET_SEL), 32'h0001);
        check("rst_rd_wr", 32'(RD_WR), 32'd1);
        check("rst_dout", 32'(DOUT), 32'h00);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        RESET_N = 1'b1;
        repeat (5) @(negedge SYSCLK);

        // Two writes to port 1 starting at offset 2
        i2c_start();
        write_byte(8'hA0, a); check("t1_addr_ack", 32'(a), 32'd1);
        check("t1_busy", 32'(BUSY), 32'd1);
        write_byte(8'h12, a); check("t1_ptr_ack", 32'(a), 32'd1);
        exp_q.push_back(pack(1'b0, 5'd1, 5'd2, 8'hA5));
        write_byte(8'hA5, a); check("t1_d0_ack", 32'(a), 32'd1);
        exp_q.push_back(pack(1'b0, 5'd1, 5'd3, 8'h3C));
        write_byte(8'h3C, a); check("t1_d1_ack", 32'(a), 32'd1);
        i2c_stop();
        check("t1_hold_offset", 32'(OFFSET_SEL), 32'h0008);
        check("t1_hold_dout", 32'(DOUT), 32'h3C);
        check("t1_hold_rd_wr", 32'(RD_WR), 32'd0);
        check("t1_busy_after_stop", 32'(BUSY), 32'd0);

        // Offset wrap 15 -> 0 on port 0
        i2c_start();
        write_byte(8'hA0, a); check("t2_addr_ack", 32'(a), 32'd1);
        write_byte(8'h0F, a); check("t2_ptr_ack", 32'(a), 32'd1);
        exp_q.push_back(pack(1'b0, 5'd0, 5'd15, 8'h11));
        write_byte(8'h11, a); check("t2_d0_ack", 32'(a), 32'd1);
        exp_q.push_back(pack(1'b0, 5'd0, 5'd0, 8'h22));
        write_byte(8'h22, a); check("t2_d1_ack", 32'(a), 32'd1);
        i2c_stop();

        // Pointer write, repeated START, two-byte read
        i2c_start();
        write_byte(8'hA0, a); check("t3_addr_ack", 32'(a), 32'd1);
        write_byte(8'h10, a); check("t3_ptr_ack", 32'(a), 32'd1);
        i2c_start();
        exp_q.push_back(pack(1'b1, 5'd1, 5'd0, 8'h00));
        write_byte(8'hA1, a); check("t3_raddr_ack", 32'(a), 32'd1);
        exp_q.push_back(pack(1'b1, 5'd1, 5'd1, 8'h00));
        read_byte(1'b1, b); check("t3_rd0", 32'(b), 32'h00);
        read_byte(1'b0, b); check("t3_rd1", 32'(b), 32'h03);
        check("t3_ignore", 32'(fsm_state), 32'(ST_IGNORE));
        check("t3_sda_released", 32'(SDA_OE), 32'd0);
        i2c_stop();
        check("t3_idle", 32'(fsm_state), 32'(ST_IDLE));

        // Foreign address, then out-of-range port
        i2c_start();
        write_byte(8'hA2, a); check("t4_addr_nack", 32'(a), 32'd0);
        check("t4_ignore", 32'(fsm_state), 32'(ST_IGNORE));
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, a); check("t4_addr_ack", 32'(a), 32'd1);
        write_byte(8'h40, a); check("t4_ptr_nack", 32'(a), 32'd0);
        i2c_stop();

        // Asynchronous reset in the middle of a data byte
        i2c_start();
        write_byte(8'hA0, a); check("t5_addr_ack", 32'(a), 32'd1);
        write_byte(8'h23, a); check("t5_ptr_ack", 32'(a), 32'd1);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
        check("t5_busy_before", 32'(BUSY), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        check("t5_rst_sda_oe", 32'(SDA_OE), 32'd0);
        check("t5_rst_port_cs", 32'(PORT_CS), 32'd0);
        check("t5_rst_busy", 32'(BUSY), 32'd0);
        check("t5_rst_offset", 32'(OFFSET_SEL), 32'h0001);
        repeat (3) @(negedge SYSCLK);
        RESET_N = 1'b1;
        wait_q();
        i2c_stop();
        i2c_start();
        exp_q.push_back(pack(1'b1, 5'd0, 5'd0, 8'h00));
        write_byte(8'hA1, a); check("t5_raddr_ack", 32'(a), 32'd1);
        read_byte(1'b0, b); check("t5_rd0", 32'(b), 32'h00);
        i2c_stop();

        // Two-cycle SDA low pulse while SCL is high inside a data byte
        gdata = 8'hC3;
        i2c_start();
        write_byte(8'hA0, a); check("t6_addr_ack", 32'(a), 32'd1);
        write_byte(8'h00, a); check("t6_ptr_ack", 32'(a), 32'd1);
`ifdef I2C_GLITCH_FILTER_EN
        exp_q.push_back(pack(1'b0, 5'd0, 5'd0, 8'hC3));
`endif
        wait_q();
        sda_m = gdata[7];
        wait_q();
        scl_m = 1'b1;
        repeat (4) @(negedge SYSCLK);
        sda_m = 1'b0;
        repeat (2) @(negedge SYSCLK);
        sda_m = 1'b1;
        repeat (2*Q-6) @(negedge SYSCLK);
        scl_m = 1'b0;
        for (int i = 6; i >= 0; i--) clock_bit(gdata[i], s);
        clock_bit(1'b1, s);
`ifdef I2C_GLITCH_FILTER_EN
        check("t6_data_ack", 32'(s == 1'b0), 32'd1);
        check("t6_busy", 32'(BUSY), 32'd1);
`else
        check("t6_data_ack", 32'(s == 1'b0), 32'd0);
        check("t6_busy", 32'(BUSY), 32'd0);
`endif
        i2c_stop();

        repeat (10) @(negedge SYSCLK);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(BUSY), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
